// File: rtl/rf_wb_arbiter_if.sv
// Writeback request/grant bundle between the requesters and the register-file write-port arbiter.
// The master side drives requests and observes grants; the slave side (the arbiter) drives the grants and the RF write port.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Arbitrates NREQ writeback requesters onto the single RF write port, with a registered one-cycle write pulse.
// Define WB_FIXED_PRIO_EN for lowest-index-wins priority instead of the default round-robin.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  rf_wb_arbiter_if.slave  bus,
  output logic            frozen,
  output logic [CW-1:0]   wb_count,
  output logic [CW-1:0]   drop_count
);

  typedef enum logic {RUN, FROZEN} state_e;

  state_e          state_q, state_d;
  logic            rfWe_q;
  logic [AW-1:0]   rfWaddr_q;
  logic [DW-1:0]   rfWdata_q;
  logic [CW-1:0]   wbCount_q, dropCount_q;

  logic            grantEn;
  logic            winValid;
  int              winIdx;
  int              startIdx;
  int              pos;
  int              bestPos;
  logic [NREQ-1:0] ready;
  logic [AW-1:0]   winAddr;
  logic [DW-1:0]   winData;

`ifdef WB_FIXED_PRIO_EN
  assign startIdx = 0;
`else
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  assign startIdx = int'(ptr_q);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hold)  state_d = FROZEN;
      FROZEN:  if (!hold) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Each requester gets its distance from startIdx in rotation order; the nearest valid one wins.
  always_comb begin
    grantEn  = !rst && !hold && (state_q == RUN);
    bestPos  = NREQ;
    winIdx   = 0;
    pos      = 0;
    ready    = '0;
    winAddr  = '0;
    winData  = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = i - startIdx;
      if (pos < 0) pos = pos + NREQ;
      if (grantEn && bus.req_valid[i] && (pos < bestPos)) begin
        bestPos = pos;
        winIdx  = i;
      end
    end
    winValid = (bestPos < NREQ);
    for (int i = 0; i < NREQ; i++) begin
      if (winValid && (winIdx == i)) begin
        ready[i] = 1'b1;
        winAddr  = bus.req_addr[i*AW +: AW];
        winData  = bus.req_data[i*DW +: DW];
      end
    end
  end

`ifndef WB_FIXED_PRIO_EN
  always_comb begin
    ptr_d = ptr_q;
    if (winValid) ptr_d = (winIdx == NREQ - 1) ? '0 : PW'(winIdx + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  // r0 writes complete the handshake and update the address/data registers but never pulse rf_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      rfWe_q      <= 1'b0;
      rfWaddr_q   <= '0;
      rfWdata_q   <= '0;
      wbCount_q   <= '0;
      dropCount_q <= '0;
    end else begin
      state_q <= state_d;
      rfWe_q  <= winValid && (winAddr != '0);
      if (winValid) begin
        rfWaddr_q <= winAddr;
        rfWdata_q <= winData;
        if (winAddr != '0) wbCount_q   <= wbCount_q + CW'(1);
        else               dropCount_q <= dropCount_q + CW'(1);
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rf_we     = rfWe_q;
  assign bus.rf_waddr  = rfWaddr_q;
  assign bus.rf_wdata  = rfWdata_q;
  assign frozen        = (state_q == FROZEN);
  assign wb_count      = wbCount_q;
  assign drop_count    = dropCount_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, counter wrap sequence, then randomized traffic against a rotation model.
// Honours WB_FIXED_PRIO_EN the same way as the design.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          hold;
  logic          frozen;
  logic [CW-1:0] wb_count;
  logic [CW-1:0] drop_count;

  rf_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .bus        (bus),
    .frozen     (frozen),
    .wb_count   (wb_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference state: what the RF port and counters should show after each posedge.
  bit            modelOn = 1'b0;
  int            mPtr, mWb, mDrop, mWin;
  bit            mFrozen, mWe;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;

  typedef struct {
    logic               r;
    logic               h;
    logic [NREQ-1:0]    v;
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0]    eReady;
    logic               eWe;
    logic [AW-1:0]      eWaddr;
    logic [DW-1:0]      eWdata;
    logic               eFrozen;
    int                 eWb;
    int                 eDrop;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic r, logic h, logic [NREQ-1:0] v, logic [NREQ*AW-1:0] a,
                              logic [NREQ*DW-1:0] d, logic [NREQ-1:0] er, logic ewe,
                              logic [AW-1:0] ea, logic [DW-1:0] ed, logic ef, int ewb, int edr);
    vec_t t;
    t.r = r; t.h = h; t.v = v; t.a = a; t.d = d;
    t.eReady = er; t.eWe = ewe; t.eWaddr = ea; t.eWdata = ed;
    t.eFrozen = ef; t.eWb = ewb; t.eDrop = edr;
    return t;
  endfunction

  function automatic int modelWinner();
    if (rst || hold || mFrozen) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
`ifdef WB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (mPtr + k) % NREQ;
`endif
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic [NREQ-1:0] v,
                               input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d);
    logic [NREQ-1:0] er;
    @(negedge clk);
    rst = r;
    hold = h;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    #1;
    mWin = modelWinner();
    er = '0;
    if (mWin >= 0) er[mWin] = 1'b1;
    if (modelOn) begin
      checkOutput("model_ready",  bus.req_ready, er);
      checkOutput("model_we",     bus.rf_we, mWe);
      checkOutput("model_waddr",  bus.rf_waddr, mAddr);
      checkOutput("model_wdata",  bus.rf_wdata, mData);
      checkOutput("model_frozen", frozen, mFrozen);
      checkOutput("model_wb",     wb_count, mWb);
      checkOutput("model_drop",   drop_count, mDrop);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      mPtr = 0; mFrozen = 0; mWe = 0; mAddr = '0; mData = '0; mWb = 0; mDrop = 0;
      modelOn = 1'b1;
    end else begin
      mFrozen = hold;
      if (mWin >= 0) begin
        mAddr = bus.req_addr[mWin*AW +: AW];
        mData = bus.req_data[mWin*DW +: DW];
        mWe   = (mAddr != 0);
        if (mWe) mWb = (mWb + 1) % (1 << CW);
        else     mDrop = (mDrop + 1) % (1 << CW);
        mPtr = (mWin + 1) % NREQ;
      end else begin
        mWe = 1'b0;
      end
    end
  endtask

  localparam logic [NREQ*AW-1:0] A_T1 = {5'd0, 5'd5, 5'd0};
  localparam logic [NREQ*DW-1:0] D_T1 = {32'h0, 32'h1234, 32'h0};
  localparam logic [NREQ*AW-1:0] A_C  = {5'd3, 5'd2, 5'd1};
  localparam logic [NREQ*DW-1:0] D_C  = {32'h33, 32'h22, 32'h11};
  localparam logic [NREQ*AW-1:0] A_H  = {5'd0, 5'd0, 5'd7};
  localparam logic [NREQ*DW-1:0] D_H  = {32'h0, 32'h0, 32'h77};
  localparam logic [NREQ*AW-1:0] A_Z  = {5'd0, 5'd0, 5'd0};
  localparam logic [NREQ*DW-1:0] D_Z  = {32'hDEAD, 32'h0, 32'h0};
  localparam logic [NREQ*AW-1:0] A_M  = {5'd0, 5'd9, 5'd0};
  localparam logic [NREQ*DW-1:0] D_M  = {32'h0, 32'h99, 32'h0};

  initial begin
    logic [AW-1:0] lastA;
    logic [DW-1:0] lastD;
    logic [NREQ*AW-1:0] ra;
    logic [NREQ*DW-1:0] rd;

    rst = 1'b1;
    hold = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    mWin = -1;

    vecs[0]  = mk(1, 0, 3'b111, A_C,  D_C,  3'b000, 0, 5'd0, 32'h0,    0, 0, 0);
    vecs[1]  = mk(0, 0, 3'b010, A_T1, D_T1, 3'b010, 0, 5'd0, 32'h0,    0, 0, 0);
    vecs[2]  = mk(0, 0, 3'b000, A_T1, D_T1, 3'b000, 1, 5'd5, 32'h1234, 0, 1, 0);
    vecs[3]  = mk(1, 0, 3'b000, A_T1, D_T1, 3'b000, 0, 5'd5, 32'h1234, 0, 1, 0);
    vecs[4]  = mk(0, 0, 3'b111, A_C,  D_C,  3'b001, 0, 5'd0, 32'h0,    0, 0, 0);
`ifdef WB_FIXED_PRIO_EN
    vecs[5]  = mk(0, 0, 3'b111, A_C, D_C, 3'b001, 1, 5'd1, 32'h11, 0, 1, 0);
    vecs[6]  = mk(0, 0, 3'b111, A_C, D_C, 3'b001, 1, 5'd1, 32'h11, 0, 2, 0);
    vecs[7]  = mk(0, 0, 3'b111, A_C, D_C, 3'b001, 1, 5'd1, 32'h11, 0, 3, 0);
    vecs[8]  = mk(0, 0, 3'b111, A_C, D_C, 3'b001, 1, 5'd1, 32'h11, 0, 4, 0);
    vecs[9]  = mk(0, 0, 3'b111, A_C, D_C, 3'b001, 1, 5'd1, 32'h11, 0, 5, 0);
    vecs[10] = mk(0, 0, 3'b000, A_C, D_C, 3'b000, 1, 5'd1, 32'h11, 0, 6, 0);
    lastA = 5'd1; lastD = 32'h11;
`else
    vecs[5]  = mk(0, 0, 3'b111, A_C, D_C, 3'b010, 1, 5'd1, 32'h11, 0, 1, 0);
    vecs[6]  = mk(0, 0, 3'b111, A_C, D_C, 3'b100, 1, 5'd2, 32'h22, 0, 2, 0);
    vecs[7]  = mk(0, 0, 3'b111, A_C, D_C, 3'b001, 1, 5'd3, 32'h33, 0, 3, 0);
    vecs[8]  = mk(0, 0, 3'b111, A_C, D_C, 3'b010, 1, 5'd1, 32'h11, 0, 4, 0);
    vecs[9]  = mk(0, 0, 3'b111, A_C, D_C, 3'b100, 1, 5'd2, 32'h22, 0, 5, 0);
    vecs[10] = mk(0, 0, 3'b000, A_C, D_C, 3'b000, 1, 5'd3, 32'h33, 0, 6, 0);
    lastA = 5'd3; lastD = 32'h33;
`endif
    vecs[11] = mk(0, 1, 3'b001, A_H, D_H, 3'b000, 0, lastA, lastD, 0, 6, 0);
    vecs[12] = mk(0, 1, 3'b001, A_H, D_H, 3'b000, 0, lastA, lastD, 1, 6, 0);
    vecs[13] = mk(0, 1, 3'b001, A_H, D_H, 3'b000, 0, lastA, lastD, 1, 6, 0);
    vecs[14] = mk(0, 1, 3'b001, A_H, D_H, 3'b000, 0, lastA, lastD, 1, 6, 0);
    vecs[15] = mk(0, 0, 3'b001, A_H, D_H, 3'b000, 0, lastA, lastD, 1, 6, 0);
    vecs[16] = mk(0, 0, 3'b001, A_H, D_H, 3'b001, 0, lastA, lastD, 0, 6, 0);
    vecs[17] = mk(0, 0, 3'b000, A_H, D_H, 3'b000, 1, 5'd7, 32'h77,   0, 7, 0);
    vecs[18] = mk(0, 0, 3'b100, A_Z, D_Z, 3'b100, 0, 5'd7, 32'h77,   0, 7, 0);
    vecs[19] = mk(0, 0, 3'b000, A_Z, D_Z, 3'b000, 0, 5'd0, 32'hDEAD, 0, 7, 1);
    vecs[20] = mk(0, 0, 3'b010, A_M, D_M, 3'b010, 0, 5'd0, 32'hDEAD, 0, 7, 1);
    vecs[21] = mk(1, 0, 3'b000, A_M, D_M, 3'b000, 1, 5'd9, 32'h99,   0, 8, 1);
    vecs[22] = mk(0, 0, 3'b111, A_C, D_C, 3'b001, 0, 5'd0, 32'h0,    0, 0, 0);
    vecs[23] = mk(0, 0, 3'b000, A_C, D_C, 3'b000, 1, 5'd1, 32'h11,   0, 1, 0);

    $display("[TB] initial reset");
    applyStimulus(1, 0, '0, '0, '0);
    advance();

    $display("[TB] directed vector table");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].r, vecs[i].h, vecs[i].v, vecs[i].a, vecs[i].d);
      checkOutput($sformatf("row%0d_ready", i),  bus.req_ready, vecs[i].eReady);
      checkOutput($sformatf("row%0d_we", i),     bus.rf_we, vecs[i].eWe);
      checkOutput($sformatf("row%0d_waddr", i),  bus.rf_waddr, vecs[i].eWaddr);
      checkOutput($sformatf("row%0d_wdata", i),  bus.rf_wdata, vecs[i].eWdata);
      checkOutput($sformatf("row%0d_frozen", i), frozen, vecs[i].eFrozen);
      checkOutput($sformatf("row%0d_wb", i),     wb_count, vecs[i].eWb);
      checkOutput($sformatf("row%0d_drop", i),   drop_count, vecs[i].eDrop);
      advance();
    end

    $display("[TB] counter wrap after 17 writes");
    applyStimulus(1, 0, '0, '0, '0);
    advance();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 0, 3'b001, {5'd0, 5'd0, 5'd4}, {64'h0, 32'(i + 100)});
      advance();
    end
    applyStimulus(0, 0, '0, '0, '0);
    checkOutput("wrap_wb", wb_count, 1);
    checkOutput("wrap_we", bus.rf_we, 1);
    checkOutput("wrap_wdata", bus.rf_wdata, 32'd116);
    advance();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        ra[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
        rd[i*DW +: DW] = $urandom;
      end
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
                    NREQ'($urandom), ra, rd);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
